// File: rtl/dly_coarse_ctrl_if.sv
// -----------------------------------------------------------------------------
// dly_coarse_ctrl_if
//   Groups the coarse delay controller's enable, phase-detector and status
//   signals into one bundle.
//
//   Parameters
//     N_CELL : number of coarse cells in the chain (width of o_sel)
//     CODE_W : width of the coarse code
//
//   Signals
//     i_en            controller enable (level)
//     i_pd_vld        phase-detector sample strobe
//     i_pd_up         delay too short, request a larger code
//     i_pd_dn         delay too long, request a smaller code
//     o_code          current coarse code
//     o_sel           thermometer select to the cell chain
//     o_lock          lock indicator
//     o_ovf / o_unf   sticky range-limit flags
//     o_busy          controller is not idle
//   Optional (macro DLY_COARSE_CTRL_OVR_EN)
//     i_ovr_en        force the code from i_ovr_code
//     i_ovr_code      override code (clamped to N_CELL-1)
//
//   Modports
//     master : the side driving enable / phase-detector inputs
//     slave  : the controller itself
// -----------------------------------------------------------------------------
interface dly_coarse_ctrl_if #(
    parameter int N_CELL = 32,
    parameter int CODE_W = 5
);
    logic              i_en;
    logic              i_pd_vld;
    logic              i_pd_up;
    logic              i_pd_dn;
`ifdef DLY_COARSE_CTRL_OVR_EN
    logic              i_ovr_en;
    logic [CODE_W-1:0] i_ovr_code;
`endif
    logic [CODE_W-1:0] o_code;
    logic [N_CELL-1:0] o_sel;
    logic              o_lock;
    logic              o_ovf;
    logic              o_unf;
    logic              o_busy;

    modport master (
`ifdef DLY_COARSE_CTRL_OVR_EN
        output i_ovr_en,
        output i_ovr_code,
`endif
        output i_en,
        output i_pd_vld,
        output i_pd_up,
        output i_pd_dn,
        input  o_code,
        input  o_sel,
        input  o_lock,
        input  o_ovf,
        input  o_unf,
        input  o_busy
    );

    modport slave (
`ifdef DLY_COARSE_CTRL_OVR_EN
        input  i_ovr_en,
        input  i_ovr_code,
`endif
        input  i_en,
        input  i_pd_vld,
        input  i_pd_up,
        input  i_pd_dn,
        output o_code,
        output o_sel,
        output o_lock,
        output o_ovf,
        output o_unf,
        output o_busy
    );
endinterface

// File: rtl/dly_coarse_ctrl.sv
// -----------------------------------------------------------------------------
// dly_coarse_ctrl
//   Coarse delay-line controller for the DLL. Filters early/late votes from
//   the phase detector, steps a coarse code up or down, drives the cell chain
//   with a thermometer select and reports lock and range-limit status.
//
//   Ports
//     i_clk  : controller clock
//     i_rst  : asynchronous active-high reset
//     bus    : dly_coarse_ctrl_if.slave (enable, phase-detector inputs,
//              code / select / status outputs)
//
//   Optional feature
//     DLY_COARSE_CTRL_OVR_EN : adds i_ovr_en / i_ovr_code to the interface;
//     while i_ovr_en is high the code follows i_ovr_code (clamped) and the
//     FSM is parked in SETTLE with lock cleared.
//
//   All outputs are registered; o_sel is registered alongside o_code so the
//   chain never sees a select vector that disagrees with the code.
// -----------------------------------------------------------------------------
module dly_coarse_ctrl #(
    parameter int N_CELL     = 32,
    parameter int CODE_W     = 5,
    parameter int INIT_CODE  = 8,
    parameter int FILT_TH    = 4,
    parameter int SETTLE_CYC = 8,
    parameter int LOCK_REV   = 3
) (
    input logic               i_clk,
    input logic               i_rst,
    dly_coarse_ctrl_if.slave  bus
);

    localparam int FILT_W = $clog2(FILT_TH + 1) + 1;
    localparam int CNT_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int REV_W  = $clog2(LOCK_REV + 1);

    localparam logic [CODE_W-1:0]        INIT     = CODE_W'(INIT_CODE);
    localparam logic [CODE_W-1:0]        MAX_CODE = CODE_W'(N_CELL - 1);
    localparam logic signed [FILT_W-1:0] TH_POS   = FILT_W'(FILT_TH);
    localparam logic signed [FILT_W-1:0] TH_NEG   = -FILT_W'(FILT_TH);
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [REV_W-1:0]         REV_MAX  = REV_W'(LOCK_REV);

    typedef enum logic [1:0] {IDLE, SETTLE, TRACK} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

    state_t                     state_q, state_n;
    dir_t                       dir_q, dir_n, step_dir;
    logic [CODE_W-1:0]          code_q, code_n;
    logic [N_CELL-1:0]          sel_q, sel_n;
    logic signed [FILT_W-1:0]   filt_q, filt_n, filt_upd;
    logic [CNT_W-1:0]           cnt_q, cnt_n;
    logic [REV_W-1:0]           rev_q, rev_n, rev_inc;
    logic                       lock_q, lock_n;
    logic                       ovf_q, ovf_n;
    logic                       unf_q, unf_n;
    logic                       busy_q, busy_n;
    logic                       step_up, step_dn;

    // Thermometer select: cell k is selected when k is at or above the code.
    function automatic logic [N_CELL-1:0] therm(input logic [CODE_W-1:0] c);
        logic [N_CELL-1:0] v;
        for (int k = 0; k < N_CELL; k++) begin
            v[k] = (k >= int'(c));
        end
        return v;
    endfunction

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_NONE;
            code_q  <= INIT;
            sel_q   <= therm(INIT);
            filt_q  <= '0;
            cnt_q   <= '0;
            rev_q   <= '0;
            lock_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            dir_q   <= dir_n;
            code_q  <= code_n;
            sel_q   <= sel_n;
            filt_q  <= filt_n;
            cnt_q   <= cnt_n;
            rev_q   <= rev_n;
            lock_q  <= lock_n;
            ovf_q   <= ovf_n;
            unf_q   <= unf_n;
            busy_q  <= busy_n;
        end
    end

    // Next-state logic. The filter never needs explicit clamping: reaching
    // either threshold always clears it, so it stays within +/-FILT_TH.
    always_comb begin
        state_n  = state_q;
        dir_n    = dir_q;
        code_n   = code_q;
        filt_n   = filt_q;
        cnt_n    = cnt_q;
        rev_n    = rev_q;
        lock_n   = lock_q;
        ovf_n    = ovf_q;
        unf_n    = unf_q;
        filt_upd = filt_q;
        step_up  = 1'b0;
        step_dn  = 1'b0;
        step_dir = DIR_NONE;
        rev_inc  = (rev_q == REV_MAX) ? rev_q : rev_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.i_en) begin
                    state_n = SETTLE;
                    code_n  = INIT;
                    filt_n  = '0;
                    cnt_n   = '0;
                    rev_n   = '0;
                    dir_n   = DIR_NONE;
                    lock_n  = 1'b0;
                    ovf_n   = 1'b0;
                    unf_n   = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_n = TRACK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            TRACK: begin
                if (bus.i_pd_vld) begin
                    if (bus.i_pd_up && !bus.i_pd_dn) begin
                        filt_upd = filt_q + FILT_W'(1);
                    end else if (bus.i_pd_dn && !bus.i_pd_up) begin
                        filt_upd = filt_q - FILT_W'(1);
                    end
                    if (filt_upd >= TH_POS) begin
                        filt_n = '0;
                        if (code_q != MAX_CODE) step_up = 1'b1;
                        else                    ovf_n   = 1'b1;
                    end else if (filt_upd <= TH_NEG) begin
                        filt_n = '0;
                        if (code_q != '0) step_dn = 1'b1;
                        else              unf_n   = 1'b1;
                    end else begin
                        filt_n = filt_upd;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (step_up) begin
            code_n   = code_q + 1'b1;
            unf_n    = 1'b0;
            step_dir = DIR_UP;
        end
        if (step_dn) begin
            code_n   = code_q - 1'b1;
            ovf_n    = 1'b0;
            step_dir = DIR_DN;
        end

        // Lock bookkeeping: reversals accumulate, a repeated direction
        // (two consecutive same-direction steps) drops lock.
        if (step_up || step_dn) begin
            state_n = SETTLE;
            cnt_n   = '0;
            dir_n   = step_dir;
            if (dir_q != DIR_NONE) begin
                if (dir_q != step_dir) begin
                    rev_n = rev_inc;
                    if (rev_inc == REV_MAX) lock_n = 1'b1;
                end else begin
                    rev_n  = '0;
                    lock_n = 1'b0;
                end
            end
        end

        // Disable wins over any step in flight; the code stays where it is.
        if (!bus.i_en) begin
            state_n = IDLE;
            code_n  = code_q;
            dir_n   = dir_q;
            rev_n   = rev_q;
            ovf_n   = ovf_q;
            unf_n   = unf_q;
            filt_n  = '0;
            cnt_n   = '0;
            lock_n  = 1'b0;
        end

`ifdef DLY_COARSE_CTRL_OVR_EN
        // Override parks the FSM in SETTLE so tracking restarts cleanly from
        // the forced code once released.
        if (bus.i_ovr_en) begin
            state_n = SETTLE;
            code_n  = (bus.i_ovr_code > MAX_CODE) ? MAX_CODE : bus.i_ovr_code;
            cnt_n   = '0;
            filt_n  = '0;
            lock_n  = 1'b0;
        end
`endif

        sel_n  = therm(code_n);
        busy_n = (state_n != IDLE);
    end

    assign bus.o_code = code_q;
    assign bus.o_sel  = sel_q;
    assign bus.o_lock = lock_q;
    assign bus.o_ovf  = ovf_q;
    assign bus.o_unf  = unf_q;
    assign bus.o_busy = busy_q;

endmodule

// File: tb/tb_dly_coarse_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dly_coarse_ctrl
//   Directed bench for the coarse delay controller: a vector table for the
//   enable / filter / step-up path, then hand-written sequences for lock,
//   disable, range saturation and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_dly_coarse_ctrl;

    localparam int N_CELL     = 32;
    localparam int CODE_W     = 5;
    localparam int INIT_CODE  = 8;
    localparam int FILT_TH    = 4;
    localparam int SETTLE_CYC = 8;
    localparam int LOCK_REV   = 3;

    typedef struct {
        logic       en;
        logic       vld;
        logic       up;
        logic       dn;
        logic [4:0] code;
        logic       busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   exp_code;
    vec_t vecs[$];

    dly_coarse_ctrl_if #(.N_CELL(N_CELL), .CODE_W(CODE_W)) bus ();

    dly_coarse_ctrl #(
        .N_CELL    (N_CELL),
        .CODE_W    (CODE_W),
        .INIT_CODE (INIT_CODE),
        .FILT_TH   (FILT_TH),
        .SETTLE_CYC(SETTLE_CYC),
        .LOCK_REV  (LOCK_REV)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Independent thermometer reference: ones from bit 'code' upward.
    function automatic logic [31:0] exp_sel(input int code);
        logic [31:0] ones;
        ones = '1;
        return ones << code;
    endfunction

    function automatic void add_vec(input logic en, input logic vld, input logic up,
                                    input logic dn, input int code, input logic busy);
        vec_t v;
        v.en   = en;
        v.vld  = vld;
        v.up   = up;
        v.dn   = dn;
        v.code = 5'(code);
        v.busy = busy;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs, then let the edge pass before sampling.
    task automatic applyStimulus(input logic en, input logic vld, input logic up, input logic dn);
        bus.i_en     = en;
        bus.i_pd_vld = vld;
        bus.i_pd_up  = up;
        bus.i_pd_dn  = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic checkAll(input string name, input int code, input logic lock,
                            input logic ovf, input logic unf, input logic busy);
        checkOutput({name, "_code"}, 64'(bus.o_code), 64'(code));
        checkOutput({name, "_sel"},  64'(bus.o_sel),  64'(exp_sel(code)));
        checkOutput({name, "_lock"}, 64'(bus.o_lock), 64'(lock));
        checkOutput({name, "_ovf"},  64'(bus.o_ovf),  64'(ovf));
        checkOutput({name, "_unf"},  64'(bus.o_unf),  64'(unf));
        checkOutput({name, "_busy"}, 64'(bus.o_busy), 64'(busy));
    endtask

    task automatic settle();
        repeat (SETTLE_CYC) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic vote(input int n, input logic up);
        repeat (n) applyStimulus(1'b1, 1'b1, up, !up);
    endtask

    // One full step from the start of a settle window.
    task automatic stepTo(input logic up);
        settle();
        vote(FILT_TH, up);
        exp_code = up ? exp_code + 1 : exp_code - 1;
        checkOutput($sformatf("step_to_%0d", exp_code), 64'(bus.o_code), 64'(exp_code));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.i_en     = 1'b0;
        bus.i_pd_vld = 1'b0;
        bus.i_pd_up  = 1'b0;
        bus.i_pd_dn  = 1'b0;
`ifdef DLY_COARSE_CTRL_OVR_EN
        bus.i_ovr_en   = 1'b0;
        bus.i_ovr_code = '0;
`endif

        // Vector table: enable, votes ignored while settling, cancelling
        // votes, ignored patterns, then two filtered up-steps.
        add_vec(1, 0, 0, 0, 8, 1);
        for (int i = 0; i < SETTLE_CYC; i++) add_vec(1, 1, 1, 0, 8, 1);
        for (int i = 0; i < 10; i++) begin
            add_vec(1, 1, 1, 0, 8, 1);
            add_vec(1, 1, 0, 1, 8, 1);
        end
        for (int i = 0; i < 4; i++) add_vec(1, 1, 1, 1, 8, 1);
        for (int i = 0; i < 4; i++) add_vec(1, 0, 1, 0, 8, 1);
        for (int i = 0; i < 4; i++) add_vec(1, 0, 0, 1, 8, 1);
        for (int i = 0; i < 3; i++) add_vec(1, 1, 1, 0, 8, 1);
        add_vec(1, 1, 1, 0, 9, 1);
        for (int i = 0; i < SETTLE_CYC; i++) add_vec(1, 1, 1, 0, 9, 1);
        for (int i = 0; i < 3; i++) add_vec(1, 1, 1, 0, 9, 1);
        add_vec(1, 1, 1, 0, 10, 1);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkAll("reset", 8, 0, 0, 0, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("idle", 8, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].en, vecs[i].vld, vecs[i].up, vecs[i].dn);
            checkOutput($sformatf("vec%0d_code", i), 64'(bus.o_code), 64'(vecs[i].code));
            checkOutput($sformatf("vec%0d_sel", i),  64'(bus.o_sel),  64'(exp_sel(int'(vecs[i].code))));
            checkOutput($sformatf("vec%0d_busy", i), 64'(bus.o_busy), 64'(vecs[i].busy));
            checkOutput($sformatf("vec%0d_lock", i), 64'(bus.o_lock), 64'(0));
        end

        // Restart from INIT_CODE and build lock with alternating steps.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("dis_a", 10, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkAll("reen_a", 8, 0, 0, 0, 1);
        exp_code = 8;
        stepTo(1'b1);
        stepTo(1'b0);
        stepTo(1'b1);
        checkOutput("lock_after_2rev", 64'(bus.o_lock), 64'(0));
        stepTo(1'b0);
        checkOutput("lock_after_3rev", 64'(bus.o_lock), 64'(1));
        stepTo(1'b0);
        stepTo(1'b0);
        checkOutput("lock_after_dn_dn", 64'(bus.o_lock), 64'(0));

        // Relock, then disable mid-filter while locked.
        stepTo(1'b1);
        stepTo(1'b0);
        stepTo(1'b1);
        checkOutput("relock", 64'(bus.o_lock), 64'(1));
        settle();
        vote(2, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkAll("dis_b", 7, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkAll("reen_b", 8, 0, 0, 0, 1);
        settle();
        vote(FILT_TH - 1, 1'b1);
        checkOutput("filt_cleared", 64'(bus.o_code), 64'(8));
        vote(1, 1'b1);
        checkOutput("filt_fresh_step", 64'(bus.o_code), 64'(9));
        exp_code = 9;

        // Upper limit.
        repeat (22) stepTo(1'b1);
        settle();
        vote(FILT_TH, 1'b1);
        checkOutput("sat_hi_code", 64'(bus.o_code), 64'(31));
        checkOutput("sat_hi_ovf",  64'(bus.o_ovf),  64'(1));
        checkOutput("sat_hi_busy", 64'(bus.o_busy), 64'(1));
        vote(FILT_TH, 1'b0);
        checkOutput("off_hi_code", 64'(bus.o_code), 64'(30));
        checkOutput("off_hi_ovf",  64'(bus.o_ovf),  64'(0));
        exp_code = 30;

        // Lower limit.
        repeat (30) stepTo(1'b0);
        settle();
        vote(FILT_TH, 1'b0);
        checkOutput("sat_lo_code", 64'(bus.o_code), 64'(0));
        checkOutput("sat_lo_unf",  64'(bus.o_unf),  64'(1));
        checkOutput("sat_lo_sel",  64'(bus.o_sel),  64'(32'hFFFF_FFFF));
        vote(FILT_TH, 1'b1);
        checkOutput("off_lo_code", 64'(bus.o_code), 64'(1));
        checkOutput("off_lo_unf",  64'(bus.o_unf),  64'(0));
        checkOutput("off_lo_ovf",  64'(bus.o_ovf),  64'(0));
        settle();
        vote(FILT_TH, 1'b0);
        settle();
        vote(FILT_TH, 1'b0);
        checkOutput("sat_lo2_unf", 64'(bus.o_unf), 64'(1));

        // Asynchronous reset mid-settle.
        vote(FILT_TH, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkAll("async_rst", 8, 0, 0, 0, 0);
        checkOutput("async_rst_sel", 64'(bus.o_sel), 64'(32'hFFFF_FF00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
